// File: rtl/imem_access_arbiter_if.sv
// Fetch, loader and byte-memory signal bundle
// for the instruction memory access arbiter.
interface imem_access_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          ld_req_valid;
  logic          ld_req_ready;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_rsp_valid;
  logic [DW-1:0] ld_rsp_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport slave (
    input  if_req_valid, if_addr, if_flush,
    input  ld_req_valid, ld_we, ld_addr,
    input  ld_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid,
    output if_rsp_data, ld_req_ready,
    output ld_rsp_valid, ld_rsp_rdata,
    output mem_en, mem_we, mem_addr,
    output mem_wdata
  );

  modport master (
    output if_req_valid, if_addr, if_flush,
    output ld_req_valid, ld_we, ld_addr,
    output ld_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid,
    input  if_rsp_data, ld_req_ready,
    input  ld_rsp_valid, ld_rsp_rdata,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Shares a byte-wide instruction memory between
// fetch (read-only) and loader (read/write) ports.
module imem_access_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0
) (
  input logic clk,
  input logic rst_n,
  imem_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic          own_if_q, own_if_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [23:0]   rbuf_q, rbuf_d;
  logic          flush_q, flush_d;
  logic          rr_ld_q, rr_ld_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          if_vld_q, if_vld_d;
  logic [DW-1:0] if_data_q, if_data_d;
  logic          ld_vld_q, ld_vld_d;
  logic [DW-1:0] ld_data_q, ld_data_d;
  logic          gnt_if, gnt_ld;
  logic [1:0]    nbeat;
  logic [31:0]   word;

  function automatic logic [7:0] byte_of(
    input logic [31:0] w,
    input logic [1:0]  b
  );
    logic [7:0] r;
    unique case (b)
      2'd0: r = w[31:24];
      2'd1: r = w[23:16];
      2'd2: r = w[15:8];
      default: r = w[7:0];
    endcase
    return r;
  endfunction

  // Grant decision, only meaningful while idle
  always_comb begin
    gnt_ld = 1'b0;
    gnt_if = 1'b0;
    if (state_q == IDLE) begin
      gnt_ld = bus.ld_req_valid &
               ((ARB_MODE != 0) |
                ~bus.if_req_valid | rr_ld_q);
      gnt_if = bus.if_req_valid & ~gnt_ld;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    own_if_d    = own_if_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    flush_d     = flush_q;
    rr_ld_d     = rr_ld_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_vld_d    = 1'b0;
    if_data_d   = if_data_q;
    ld_vld_d    = 1'b0;
    ld_data_d   = ld_data_q;
    word        = {rbuf_q, bus.mem_rdata};
    nbeat       = beat_q + 2'd1;
    unique case (state_q)
      IDLE: begin
        if (gnt_if | gnt_ld) begin
          state_d     = ISSUE;
          beat_d      = 2'd0;
          own_if_d    = gnt_if;
          we_d        = gnt_ld & bus.ld_we;
          addr_d      = gnt_if ? bus.if_addr
                               : bus.ld_addr;
          wdata_d     = gnt_ld ? bus.ld_wdata
                               : '0;
          flush_d     = gnt_if & bus.if_flush;
          rr_ld_d     = gnt_if;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = byte_of(wdata_d, 2'd0);
        end
      end
      ISSUE: begin
        flush_d = flush_q |
                  (own_if_q & bus.if_flush);
        if (beat_q != 2'd0 && !we_q)
          rbuf_d = word[23:0];
        if (beat_q == 2'd3) begin
          state_d = we_q ? RESP : DRAIN;
          if (we_q) begin
            ld_vld_d  = 1'b1;
            ld_data_d = '0;
          end
        end else begin
          beat_d      = nbeat;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + AW'(nbeat);
          mem_wdata_d = byte_of(wdata_q, nbeat);
        end
      end
      DRAIN: begin
        state_d = RESP;
        flush_d = flush_q |
                  (own_if_q & bus.if_flush);
        if (own_if_q) begin
          if (!flush_d) begin
            if_vld_d  = 1'b1;
            if_data_d = word;
          end
        end else begin
          ld_vld_d  = 1'b1;
          ld_data_d = word;
        end
      end
      default: begin
        state_d = IDLE;
        flush_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      own_if_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      flush_q     <= 1'b0;
      rr_ld_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_vld_q    <= 1'b0;
      if_data_q   <= '0;
      ld_vld_q    <= 1'b0;
      ld_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      own_if_q    <= own_if_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      flush_q     <= flush_d;
      rr_ld_q     <= rr_ld_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_vld_q    <= if_vld_d;
      if_data_q   <= if_data_d;
      ld_vld_q    <= ld_vld_d;
      ld_data_q   <= ld_data_d;
    end
  end

  // A flush in the response cycle still kills it
  assign bus.if_rsp_valid = if_vld_q & ~bus.if_flush;
  assign bus.if_rsp_data  = if_data_q;
  assign bus.ld_rsp_valid = ld_vld_q;
  assign bus.ld_rsp_rdata = ld_data_q;
  assign bus.if_req_ready = gnt_if;
  assign bus.ld_req_ready = gnt_ld;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
endmodule

// File: tb/tb_imem_access_arbiter.sv
// Randomized bench for imem_access_arbiter with a
// transaction-level reference model.
module tb_imem_access_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_access_arbiter_if #(.AW(AW), .DW(DW)) bus0();
  imem_access_arbiter_if #(.AW(AW), .DW(DW)) bus1();

  imem_access_arbiter #(
    .AW(AW), .DW(DW), .ARB_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  imem_access_arbiter #(
    .AW(AW), .DW(DW), .ARB_MODE(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(
    input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // byte memory attached to DUT0
  logic [7:0] mem0 [logic [31:0]];
  always @(posedge clk) begin
    if (bus0.mem_en) begin
      if (bus0.mem_we)
        mem0[bus0.mem_addr] = bus0.mem_wdata;
      else
        bus0.mem_rdata <=
          mem0.exists(bus0.mem_addr) ?
          mem0[bus0.mem_addr] :
          init_byte(bus0.mem_addr);
    end
  end

  // reference model state
  logic [7:0] ref_mem [logic [31:0]];
  bit          busy = 0;
  int          t_acc = 0;
  bit          p_if, p_we, p_fl;
  logic [31:0] p_addr, p_wdata, p_exp;
  bit          last_if = 0;
  bit          acc_if = 0, acc_ld = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  int          n_if_rsp = 0;
  int          last_if_cyc = 0, last_ld_cyc = 0;
  logic [31:0] last_if_data, last_ld_data;
  bit          gseq[$];

  function automatic logic [7:0] ref_byte(
    input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a]
                             : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(
    input logic [31:0] a);
    return {ref_byte(a), ref_byte(a + 1),
            ref_byte(a + 2), ref_byte(a + 3)};
  endfunction

  task automatic step();
    int d;
    bit gi, gl, en_e, r;
    logic [31:0] a;
    if (busy && cyc >= t_acc + (p_we ? 6 : 7))
      busy = 0;
    gl = !busy && bus0.ld_req_valid &&
         (!bus0.if_req_valid || last_if);
    gi = !busy && bus0.if_req_valid && !gl;
    chk("if_ready", 32'(bus0.if_req_ready), 32'(gi));
    chk("ld_ready", 32'(bus0.ld_req_ready), 32'(gl));
    d = cyc - t_acc;
    if (busy && p_if && bus0.if_flush) p_fl = 1;
    en_e = busy && d >= 1 && d <= 4;
    chk("mem_en", 32'(bus0.mem_en), 32'(en_e));
    if (en_e) begin
      a = p_addr + 32'(d - 1);
      chk("mem_addr", bus0.mem_addr, a);
      chk("mem_we", 32'(bus0.mem_we), 32'(p_we));
      if (p_we)
        chk("mem_wdata", 32'(bus0.mem_wdata),
            (p_wdata >> (8 * (4 - d))) & 32'hFF);
    end
    r = busy && d == (p_we ? 5 : 6);
    chk("if_rsp_valid", 32'(bus0.if_rsp_valid),
        32'(r && p_if && !p_fl));
    chk("ld_rsp_valid", 32'(bus0.ld_rsp_valid),
        32'(r && !p_if));
    if (r && p_if && !p_fl) begin
      chk("if_rsp_data", bus0.if_rsp_data, p_exp);
      n_if_rsp++;
      last_if_cyc = cyc;
      last_if_data = bus0.if_rsp_data;
    end
    if (r && !p_if) begin
      chk("ld_rsp_rdata", bus0.ld_rsp_rdata,
          p_we ? 32'h0 : p_exp);
      last_ld_cyc = cyc;
      last_ld_data = bus0.ld_rsp_rdata;
    end
    acc_if = gi;
    acc_ld = gl;
    if (gi || gl) begin
      busy = 1;
      t_acc = cyc;
      last_acc_cyc = cyc;
      p_if = gi;
      p_we = gl && bus0.ld_we;
      p_addr = gi ? bus0.if_addr : bus0.ld_addr;
      p_wdata = bus0.ld_wdata;
      p_fl = gi && bus0.if_flush;
      if (p_we) begin
        for (int i = 0; i < 4; i++)
          ref_mem[p_addr + 32'(i)] =
            8'((p_wdata >> (8 * (3 - i))) & 32'hFF);
      end else begin
        p_exp = ref_word(p_addr);
      end
      last_if = gi;
      gseq.push_back(gi);
    end
    cyc++;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    if (acc_if) bus0.if_req_valid = 1'b0;
    if (acc_ld) bus0.ld_req_valid = 1'b0;
    acc_if = 0;
    acc_ld = 0;
    bus0.if_flush = 1'b0;
  endtask

  task automatic eval();
    #1;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next_cycle();
      eval();
    end
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = 32'hFFFF_FFFE;
      1: a = 32'h10;
      default: a = 32'h100 + $urandom_range(0, 63);
    endcase
    return a;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_en"}, 32'(bus0.mem_en), 0);
    chk({tag, "_mem_we"}, 32'(bus0.mem_we), 0);
    chk({tag, "_mem_addr"}, bus0.mem_addr, 0);
    chk({tag, "_mem_wdata"}, 32'(bus0.mem_wdata), 0);
    chk({tag, "_if_rsp"}, 32'(bus0.if_rsp_valid), 0);
    chk({tag, "_ld_rsp"}, 32'(bus0.ld_rsp_valid), 0);
    chk({tag, "_if_data"}, bus0.if_rsp_data, 0);
    chk({tag, "_ld_data"}, bus0.ld_rsp_rdata, 0);
  endtask

  initial begin
    int a1, n0, nacc;
    bus0.if_req_valid = 0; bus0.if_addr = 0;
    bus0.if_flush = 0; bus0.ld_req_valid = 0;
    bus0.ld_we = 0; bus0.ld_addr = 0;
    bus0.ld_wdata = 0; bus0.mem_rdata = 0;
    bus1.if_req_valid = 0; bus1.if_addr = 0;
    bus1.if_flush = 0; bus1.ld_req_valid = 0;
    bus1.ld_we = 0; bus1.ld_addr = 0;
    bus1.ld_wdata = 0; bus1.mem_rdata = 0;
    mem0[32'h10] = 8'hAA; ref_mem[32'h10] = 8'hAA;
    mem0[32'h11] = 8'hBB; ref_mem[32'h11] = 8'hBB;
    mem0[32'h12] = 8'hCC; ref_mem[32'h12] = 8'hCC;
    mem0[32'h13] = 8'hDD; ref_mem[32'h13] = 8'hDD;

    repeat (3) @(negedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    eval();

    // 1: fetch read at 0x10
    next_cycle();
    bus0.if_req_valid = 1; bus0.if_addr = 32'h10;
    eval();
    a1 = last_acc_cyc;
    idle(8);
    chk("t1_data", last_if_data, 32'hAABBCCDD);
    chk("t1_lat", 32'(last_if_cyc - a1), 6);

    // 2: loader write then read at 0x20
    next_cycle();
    bus0.ld_req_valid = 1; bus0.ld_we = 1;
    bus0.ld_addr = 32'h20;
    bus0.ld_wdata = 32'h12345678;
    eval();
    a1 = last_acc_cyc;
    idle(7);
    chk("t2_wlat", 32'(last_ld_cyc - a1), 5);
    chk("t2_b0", 32'(mem0[32'h20]), 32'h12);
    chk("t2_b1", 32'(mem0[32'h21]), 32'h34);
    chk("t2_b2", 32'(mem0[32'h22]), 32'h56);
    chk("t2_b3", 32'(mem0[32'h23]), 32'h78);
    next_cycle();
    bus0.ld_req_valid = 1; bus0.ld_we = 0;
    bus0.ld_addr = 32'h20;
    eval();
    idle(8);
    chk("t2_rdata", last_ld_data, 32'h12345678);

    // 3: both valid, loader served last
    gseq.delete();
    repeat (30) begin
      next_cycle();
      bus0.if_req_valid = 1; bus0.if_addr = 32'h100;
      bus0.ld_req_valid = 1; bus0.ld_we = 0;
      bus0.ld_addr = 32'h104;
      eval();
    end
    next_cycle();
    bus0.if_req_valid = 0; bus0.ld_req_valid = 0;
    eval();
    idle(8);
    chk("t3_cnt", 32'(gseq.size() >= 4), 1);
    if (gseq.size() >= 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("t3_g%0d", i), 32'(gseq[i]),
            32'(i % 2 == 0));

    // 4: flush at T+3, next fetch at T+7
    n0 = n_if_rsp;
    next_cycle();
    bus0.if_req_valid = 1; bus0.if_addr = 32'h104;
    eval();
    a1 = last_acc_cyc;
    next_cycle();
    bus0.if_req_valid = 1; bus0.if_addr = 32'h108;
    eval();
    idle(1);
    next_cycle();
    bus0.if_flush = 1;
    eval();
    idle(4);
    chk("t4_next_acc", 32'(last_acc_cyc - a1), 7);
    chk("t4_no_rsp", 32'(n_if_rsp - n0), 0);
    idle(8);

    // 5: address wrap
    next_cycle();
    bus0.if_req_valid = 1;
    bus0.if_addr = 32'hFFFF_FFFE;
    eval();
    idle(8);
    chk("t5_data", last_if_data,
        {init_byte(32'hFFFF_FFFE),
         init_byte(32'hFFFF_FFFF),
         init_byte(32'h0), init_byte(32'h1)});

    // random traffic
    repeat (2000) begin
      next_cycle();
      if (!bus0.if_req_valid &&
          $urandom_range(0, 2) == 0) begin
        bus0.if_req_valid = 1;
        bus0.if_addr = pick_addr();
      end
      if (!bus0.ld_req_valid &&
          $urandom_range(0, 2) == 0) begin
        bus0.ld_req_valid = 1;
        bus0.ld_we = 1'($urandom_range(0, 1));
        bus0.ld_addr = pick_addr();
        bus0.ld_wdata = $urandom;
      end
      bus0.if_flush = ($urandom_range(0, 9) == 0);
      eval();
    end
    next_cycle();
    bus0.if_req_valid = 0; bus0.ld_req_valid = 0;
    eval();
    idle(8);

    // 6: reset during write beat 2
    next_cycle();
    bus0.ld_req_valid = 1; bus0.ld_we = 1;
    bus0.ld_addr = 32'h200;
    bus0.ld_wdata = 32'hCAFEF00D;
    eval();
    idle(2);
    next_cycle();
    rst_n = 1'b0;
    eval();
    next_cycle();
    rst_n = 1'b1;
    busy = 0;
    last_if = 0;
    #1;
    chk_zero("t6");
    chk("t6_if_rdy", 32'(bus0.if_req_ready), 0);
    chk("t6_ld_rdy", 32'(bus0.ld_req_ready), 0);
    step();
    chk("t6_b0", 32'(mem0[32'h200]), 32'hCA);
    chk("t6_b1", 32'(mem0[32'h201]), 32'hFE);
    chk("t6_b2", 32'(mem0[32'h202]), 32'hF0);
    chk("t6_b3", 32'(mem0.exists(32'h203) ?
        mem0[32'h203] : init_byte(32'h203)),
        32'(init_byte(32'h203)));
    ref_mem.delete(32'h203);
    idle(10);
    gseq.delete();
    next_cycle();
    bus0.if_req_valid = 1; bus0.if_addr = 32'h110;
    bus0.ld_req_valid = 1; bus0.ld_we = 0;
    bus0.ld_addr = 32'h114;
    eval();
    chk("t6_rr_fetch", 32'(bus0.if_req_ready), 1);
    next_cycle();
    bus0.ld_req_valid = 0;
    eval();
    idle(8);

    // ARB_MODE=1: loader wins every tie
    nacc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus1.if_req_valid = 1; bus1.ld_req_valid = 1;
      bus1.if_addr = 32'h40; bus1.ld_addr = 32'h80;
      #1;
      chk("m1_if_rsp", 32'(bus1.if_rsp_valid), 0);
      if (bus1.if_req_ready || bus1.ld_req_ready) begin
        nacc++;
        chk("m1_if_ready", 32'(bus1.if_req_ready), 0);
        chk("m1_ld_ready", 32'(bus1.ld_req_ready), 1);
      end
    end
    chk("m1_accepts", 32'(nacc), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
